countdown_timer: RTL and testbench
==================================

# countdown_timer

Minutes:seconds BCD countdown timer driven by the 1 Hz square wave from the slow-clock divider. Sits directly downstream of that divider.
- Turns each rising edge of its output into a one-`clk` tick.
- Runs a load / start / pause / expire state machine and drives four BCD digits to the display mux.
- Drives an alarm level to the buzzer/LED stage.

## Interface
- `MAX_MIN_TENS`, default 9: upper clamp for the minutes-tens digit on load.
- `clk` input 1: system clock (50 MHz); the only clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `slow_clk` input 1: 1 Hz square wave from the divider, already registered in the `clk` domain; used as data only, never as a clock.
- `start` input 1: one-cycle pulse (debounced upstream); run or resume.
- `stop` input 1: one-cycle pulse; pause, or acknowledge an expired alarm.
- `load` input 1: one-cycle pulse; load the preset digits.
- `ld_min_t`, `ld_min_o`, `ld_sec_t`, `ld_sec_o` input 4 each: preset BCD digits.
- `min_t`, `min_o`, `sec_t`, `sec_o` output 4 each: current BCD value.
- `running` output 1: high in RUN.
- `done` output 1: one-cycle pulse on expiry.
- `alarm` output 1: level, high from expiry until acknowledged or reloaded.

## Operation
- Tick generation:
  - Register `slow_clk` into `slow_q`.
  - `tick = slow_clk & ~slow_q`, giving one tick per second.
  - `slow_q` resets to 0.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority in every state: `load` > `stop` > `start` > `tick`.
- `load`, from any state:
  - Digits take the preset values, clamped: `ld_sec_o`/`ld_min_o` > 9 become 9; `ld_sec_t` > 5 becomes 5; `ld_min_t` > `MAX_MIN_TENS` becomes `MAX_MIN_TENS`.
  - Clears `alarm`; next state is IDLE.
- IDLE:
  - `start` with value ≠ 00:00 goes to RUN.
  - `start` with value = 00:00 is ignored.
  - `stop` is ignored.
- RUN:
  - `stop` goes to PAUSE with no decrement, even if `tick` is high in the same cycle.
  - `tick` decrements the value by one second (borrow chain below).
  - If the result is 00:00, go to DONE.
- PAUSE:
  - `start` goes to RUN.
  - Ticks are ignored and the value is held.
- DONE:
  - Value stays 00:00 and `alarm` = 1.
  - `start` or `stop` acknowledges: go to IDLE and clear `alarm`.
- Borrow chain, applied only on a RUN tick:
  - `sec_o` 0→9 with borrow, else −1.
  - `sec_t` consumes the borrow: 0→5 with borrow, else −1.
  - `min_o` consumes that borrow: 0→9 with borrow, else −1.
  - `min_t` consumes that borrow: −1.
  - The chain never underflows, because a tick at 00:01 ends the run.
- First second after `start` is partial: the first decrement happens on the next `slow_clk` rising edge, which can be anywhere from 1 `clk` to 1 s later. This is accepted behaviour.
- Reset mid-run aborts immediately; no `done` pulse.

## Timing
- Reset values: all digits 0, state IDLE, `running` 0, `done` 0, `alarm` 0.
- All outputs are registered.
- `slow_clk` is first seen high during cycle k; the digits show the decremented value from the next `clk` edge.
- Latency from `slow_clk` rise to display change: 1 `clk`.
- `load`, `start` and `stop` take effect at the edge that samples them; `running` reflects the new state in the following cycle.
- Expiry: at the edge that writes 00:00, in the same cycle:
  - the state becomes DONE;
  - `done` pulses for exactly 1 `clk`;
  - `alarm` rises;
  - `running` falls.
- A held `load` reloads every cycle and keeps the block in IDLE. A held `start` in RUN is harmless.

## Structure
- Package `timer_pkg` holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - constants `BCD_MAX` = 9 and `SEC_TENS_MAX` = 5;
  - the clamp function used on load.
- Sub-module `bcd_digit_dec`, instantiated four times and chained:
  - parameter: wrap value;
  - inputs: digit, decrement enable;
  - outputs: next digit, borrow-out.

## Test plan
- Reset → all digits 0, IDLE, `running`/`done`/`alarm` = 0. Then `start` → stays IDLE.
- Load 00:03, `start`, three `slow_clk` rises:
  - display reads 00:02, 00:01, 00:00;
  - `done` pulses once and `alarm` = 1;
  - `stop` clears `alarm` and returns to IDLE.
- Load 10:00, `start`, one tick → 09:59, confirming borrow through all four digits.
- In RUN at 00:45, `stop` and `tick` in the same cycle → PAUSE and value still 00:45. Extra ticks are ignored; `start` resumes, and the next tick gives 00:44.
- Load presets 0xF, 0xC, 0x7, 0xA → 99:59 with `MAX_MIN_TENS` = 9. Assert `reset_n` low mid-run → immediate 00:00, IDLE, no `done` pulse.
- In DONE, `load` 01:30 → `alarm` drops and the display reads 01:30 in IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types, digit limits and the load-time clamp for the BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
  } bcd_time_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the borrow chain: decrements when enabled, wrapping 0 -> WRAP with a borrow.
module bcd_digit_dec #(
  parameter logic [3:0] WRAP = 4'd9
) (
  input  logic [3:0] digit,
  input  logic       dec_en,
  output logic [3:0] digit_next,
  output logic       borrow
);

  always_comb begin
    digit_next = digit;
    borrow     = 1'b0;
    if (dec_en) begin
      if (digit == 4'd0) begin
        digit_next = WRAP;
        borrow     = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer stepped by rising edges of a 1 Hz level; load/start/pause/expire FSM.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int MAX_MIN_TENS = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       slow_clk,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [3:0] ld_min_t,
  input  logic [3:0] ld_min_o,
  input  logic [3:0] ld_sec_t,
  input  logic [3:0] ld_sec_o,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam logic [3:0] MIN_TENS_LIM = 4'(MAX_MIN_TENS);

  state_t    state, state_n;
  bcd_time_t cur, cur_n, dec_val;
  logic      slow_q, tick, dec_en;
  logic      alarm_n, done_n;
  logic      b_so, b_st, b_mo, b_mt;

  assign tick   = slow_clk & ~slow_q;
  assign dec_en = (state == RUN) && !load && !stop && tick;

  bcd_digit_dec #(.WRAP(BCD_MAX)) u_sec_o (
    .digit(cur.sec_o), .dec_en(dec_en), .digit_next(dec_val.sec_o), .borrow(b_so));
  bcd_digit_dec #(.WRAP(SEC_TENS_MAX)) u_sec_t (
    .digit(cur.sec_t), .dec_en(b_so), .digit_next(dec_val.sec_t), .borrow(b_st));
  bcd_digit_dec #(.WRAP(BCD_MAX)) u_min_o (
    .digit(cur.min_o), .dec_en(b_st), .digit_next(dec_val.min_o), .borrow(b_mo));
  bcd_digit_dec #(.WRAP(MIN_TENS_LIM)) u_min_t (
    .digit(cur.min_t), .dec_en(b_mo), .digit_next(dec_val.min_t), .borrow(b_mt));

  always_comb begin
    state_n = state;
    cur_n   = cur;
    alarm_n = alarm;
    done_n  = 1'b0;
    if (load) begin
      cur_n.min_t = clamp_digit(ld_min_t, MIN_TENS_LIM);
      cur_n.min_o = clamp_digit(ld_min_o, BCD_MAX);
      cur_n.sec_t = clamp_digit(ld_sec_t, SEC_TENS_MAX);
      cur_n.sec_o = clamp_digit(ld_sec_o, BCD_MAX);
      alarm_n     = 1'b0;
      state_n     = IDLE;
    end else begin
      case (state)
        IDLE:  if (start && (cur != '0)) state_n = RUN;
        RUN: begin
          if (stop) begin
            state_n = PAUSE;
          end else if (dec_en && !b_mt) begin
            // A borrow out of the minutes-tens digit cannot occur; hold rather than wrap.
            cur_n = dec_val;
            if (dec_val == '0) begin
              state_n = DONE;
              done_n  = 1'b1;
              alarm_n = 1'b1;
            end
          end
        end
        PAUSE: if (start) state_n = RUN;
        DONE: begin
          if (start || stop) begin
            state_n = IDLE;
            alarm_n = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cur     <= '0;
      slow_q  <= 1'b0;
      alarm   <= 1'b0;
      done    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      cur     <= cur_n;
      slow_q  <= slow_clk;
      alarm   <= alarm_n;
      done    <= done_n;
      running <= (state_n == RUN);
    end
  end

  assign min_t = cur.min_t;
  assign min_o = cur.min_o;
  assign sec_t = cur.sec_t;
  assign sec_o = cur.sec_o;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random traffic against a seconds-count model.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       slow_clk, start, stop, load;
  logic [3:0] ld_min_t, ld_min_o, ld_sec_t, ld_sec_o;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic       running, done, alarm;

  countdown_timer #(.MAX_MIN_TENS(9)) dut (
    .clk(clk), .reset_n(reset_n), .slow_clk(slow_clk),
    .start(start), .stop(stop), .load(load),
    .ld_min_t(ld_min_t), .ld_min_o(ld_min_o), .ld_sec_t(ld_sec_t), .ld_sec_o(ld_sec_o),
    .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
    .running(running), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_total;
  int m_mode;
  bit m_alarm, m_done, m_slowq;

  wire [15:0] digits  = {min_t, min_o, sec_t, sec_o};
  wire [18:0] dut_vec = {min_t, min_o, sec_t, sec_o, running, done, alarm};

  function automatic int clamp(input int d, input int lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic logic [15:0] to_bcd(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [18:0] exp_vec();
    return {to_bcd(m_total), m_mode == M_RUN, m_done, m_alarm};
  endfunction

  task automatic model_reset();
    m_total = 0; m_mode = M_IDLE; m_alarm = 0; m_done = 0; m_slowq = 0;
  endtask

  // Applies one clock of inputs, advances the model, and returns 1 time unit after the edge.
  task automatic drive(input bit ld, input bit st, input bit sp, input bit sc,
                       input logic [3:0] a = 0, input logic [3:0] b = 0,
                       input logic [3:0] c = 0, input logic [3:0] d = 0);
    bit tk;
    load = ld; start = st; stop = sp; slow_clk = sc;
    ld_min_t = a; ld_min_o = b; ld_sec_t = c; ld_sec_o = d;
    tk = sc && !m_slowq;
    m_done = 0;
    if (ld) begin
      m_total = (clamp(a, 9) * 10 + clamp(b, 9)) * 60 + clamp(c, 5) * 10 + clamp(d, 9);
      m_alarm = 0;
      m_mode  = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE:  if (st && m_total != 0) m_mode = M_RUN;
        M_RUN: begin
          if (sp) m_mode = M_PAUSE;
          else if (tk) begin
            m_total = m_total - 1;
            if (m_total == 0) begin
              m_mode = M_DONE; m_done = 1; m_alarm = 1;
            end
          end
        end
        M_PAUSE: if (st) m_mode = M_RUN;
        default: if (st || sp) begin m_mode = M_IDLE; m_alarm = 0; end
      endcase
    end
    m_slowq = sc;
    @(posedge clk);
    #1;
    load = 0; start = 0; stop = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; slow_clk = 0; start = 0; stop = 0; load = 0;
    ld_min_t = 0; ld_min_o = 0; ld_sec_t = 0; ld_sec_o = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (dut_vec !== 19'h0) begin
      n_err++; $display("FAIL reset_state: got %h want %h", dut_vec, 19'h0);
    end
    reset_n = 1;
    drive(0, 1, 0, 0);
    n_vec++;
    if (running !== 1'b0 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL start_at_zero: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_expire();
    logic [15:0] want [3];
    want[0] = 16'h0002; want[1] = 16'h0001; want[2] = 16'h0000;
    drive(1, 0, 0, 0, 0, 0, 0, 3);
    drive(0, 1, 0, 0);
    n_vec++;
    if (running !== 1'b1) begin
      n_err++; $display("FAIL expire_running: got %b want 1", running);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1);
      n_vec++;
      if (digits !== want[i] || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL expire_step%0d: got %h want %h", i, dut_vec, {want[i], exp_vec()});
      end
      if (i < 2) drive(0, 0, 0, 0);
    end
    n_vec++;
    if ({done, alarm, running} !== 3'b110) begin
      n_err++; $display("FAIL expire_flags: got %b want 110", {done, alarm, running});
    end
    drive(0, 0, 0, 0);
    n_vec++;
    if ({done, alarm} !== 2'b01) begin
      n_err++; $display("FAIL done_one_pulse: got %b want 01", {done, alarm});
    end
    drive(0, 0, 1, 0);
    n_vec++;
    if (alarm !== 1'b0 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL stop_ack: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_borrow();
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    n_vec++;
    if (digits !== 16'h0959 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL borrow_chain: got %h want 0959", digits);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_pause();
    drive(1, 0, 0, 0, 0, 0, 4, 5);
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 1);
    n_vec++;
    if (digits !== 16'h0045 || running !== 1'b0) begin
      n_err++; $display("FAIL stop_beats_tick: got %h run %b want 0045 run 0", digits, running);
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    n_vec++;
    if (digits !== 16'h0045 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL pause_hold: got %h want 0045", digits);
    end
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    n_vec++;
    if (running !== 1'b1) begin
      n_err++; $display("FAIL resume: got %b want 1", running);
    end
    drive(0, 0, 0, 1);
    n_vec++;
    if (digits !== 16'h0044 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL resume_tick: got %h want 0044", digits);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_clamp_reset();
    drive(1, 0, 0, 0, 4'hF, 4'hC, 4'h7, 4'hA);
    n_vec++;
    if (digits !== 16'h9959 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL load_clamp: got %h want 9959", digits);
    end
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    n_vec++;
    if (digits !== 16'h9958) begin
      n_err++; $display("FAIL clamp_tick: got %h want 9958", digits);
    end
    drive(0, 0, 0, 0);
    #2 reset_n = 0;
    #1;
    model_reset();
    n_vec++;
    if (dut_vec !== 19'h0) begin
      n_err++; $display("FAIL async_reset: got %h want 0", dut_vec);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (done !== 1'b0 || dut_vec !== 19'h0) begin
        n_err++; $display("FAIL reset_no_done: got %h want 0", dut_vec);
      end
    end
    reset_n = 1;
  endtask

  task automatic test_done_load();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    n_vec++;
    if ({done, alarm} !== 2'b11) begin
      n_err++; $display("FAIL reach_done: got %b want 11", {done, alarm});
    end
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 3, 0);
    n_vec++;
    if (digits !== 16'h0130 || {running, alarm} !== 2'b00 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL load_in_done: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    bit sc = 0;
    bit ld, st, sp;
    logic [3:0] a, b, c, d;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) sc = ~sc;
      ld = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 15) == 0);
      a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      c = 4'($urandom_range(0, 2));
      d = 4'($urandom);
      drive(ld, st, sp, sc, a, b, c, d);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_expire();
    test_borrow();
    test_pause();
    test_clamp_reset();
    test_done_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
